// File: rtl/simd_mult_pkg.sv
// Shared encodings and constants for the SIMD multiplier operand path.
// Mode codes, per-mode lane counts and packed-word geometry.
package simd_mult_pkg;

    localparam int SLICE_W  = 9;
    localparam int N_SLICES = 6;
    localparam int PACK_W   = SLICE_W * N_SLICES;
    localparam int OP_A_W   = 27;
    localparam int OP_B_W   = 18;
    localparam int LANE_W   = 4;

    typedef enum logic [1:0] {
        MODE_27X18   = 2'b00,
        MODE_SUM_9X9 = 2'b01,
        MODE_SUM_4X4 = 2'b10
    } mode_e;

    localparam logic [LANE_W-1:0] LANES_27X18   = 4'd1;
    localparam logic [LANE_W-1:0] LANES_SUM_9X9 = 4'd6;
    localparam logic [LANE_W-1:0] LANES_SUM_4X4 = 4'd12;

    // The unused code 2'b11 is treated as sum_9x9.
    function automatic mode_e coerce_mode(input logic [1:0] m);
        case (m)
            2'b00:   return MODE_27X18;
            2'b10:   return MODE_SUM_4X4;
            default: return MODE_SUM_9X9;
        endcase
    endfunction

    function automatic logic [LANE_W-1:0] lane_count(input mode_e m);
        case (m)
            MODE_27X18:   return LANES_27X18;
            MODE_SUM_4X4: return LANES_SUM_4X4;
            default:      return LANES_SUM_9X9;
        endcase
    endfunction

endpackage

// File: rtl/simd_lane_inserter.sv
// Writes one lane operand into its position of a packed 54-bit operand word.
// Bits outside the addressed lane pass through unchanged.
module simd_lane_inserter
    import simd_mult_pkg::*;
(
    input  logic [PACK_W-1:0] word_in,
    input  logic [LANE_W-1:0] lane,
    input  logic [OP_A_W-1:0] operand,
    input  mode_e             mode,
    input  logic              sign,
    output logic [PACK_W-1:0] word_out
);

    always_comb begin
        word_out = word_in;
        case (mode)
            MODE_27X18: begin
                word_out = {{(PACK_W-OP_A_W){1'b0}}, operand};
            end
            MODE_SUM_4X4: begin
                for (int s = 0; s < N_SLICES; s++) begin
                    if (lane[LANE_W-1:1] == 3'(s)) begin
                        // Odd lane owns the upper nibble and the slice's sign-extension bit.
                        if (lane[0]) begin
                            word_out[SLICE_W*s+4 +: 4] = operand[3:0];
                            word_out[SLICE_W*s+8]      = sign & operand[3];
                        end else begin
                            word_out[SLICE_W*s +: 4] = operand[3:0];
                        end
                    end
                end
            end
            default: begin
                for (int s = 0; s < N_SLICES; s++) begin
                    if (lane == LANE_W'(s)) begin
                        word_out[SLICE_W*s +: SLICE_W] = operand[SLICE_W-1:0];
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/simd_operand_packer.sv
// Packs lane operand pairs into 54-bit a/b multiplier words, one group per output transfer.
// Assembly register builds the group; output register holds it until the consumer accepts.
module simd_operand_packer
    import simd_mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_A_W-1:0] in_a,
    input  logic [OP_B_W-1:0] in_b,
    input  logic              in_a_sign,
    input  logic              in_b_sign,
    input  logic [1:0]        in_mode,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PACK_W-1:0] a,
    output logic [PACK_W-1:0] b,
    output logic              a_sign,
    output logic              b_sign,
    output logic [1:0]        mode,
    output logic [LANE_W-1:0] lanes
);

    logic [PACK_W-1:0] asm_a_q, asm_a_d, asm_b_q, asm_b_d;
    logic [LANE_W-1:0] cnt_q, cnt_d;
    mode_e             grp_mode_q, grp_mode_d;
    logic              grp_a_sign_q, grp_a_sign_d, grp_b_sign_q, grp_b_sign_d;
    logic              pending_q, pending_d;
    logic              out_valid_q, out_valid_d;
    logic [PACK_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    mode_e             out_mode_q, out_mode_d;
    logic              out_a_sign_q, out_a_sign_d, out_b_sign_q, out_b_sign_d;
    logic [LANE_W-1:0] out_lanes_q, out_lanes_d;

    logic              accept, first, complete, out_free;
    mode_e             eff_mode;
    logic              eff_a_sign, eff_b_sign;
    logic [PACK_W-1:0] base_a, base_b, ins_a, ins_b;
    logic [LANE_W-1:0] next_cnt;

    assign in_ready   = ~pending_q;
    assign accept     = in_valid & ~pending_q;
    assign first      = (cnt_q == '0);
    assign eff_mode   = first ? coerce_mode(in_mode) : grp_mode_q;
    assign eff_a_sign = first ? in_a_sign : grp_a_sign_q;
    assign eff_b_sign = first ? in_b_sign : grp_b_sign_q;
    assign base_a     = first ? '0 : asm_a_q;
    assign base_b     = first ? '0 : asm_b_q;
    assign next_cnt   = cnt_q + LANE_W'(1);
    assign complete   = accept & ((next_cnt == lane_count(eff_mode)) | in_last);
    assign out_free   = ~out_valid_q | out_ready;

    simd_lane_inserter u_ins_a (
        .word_in (base_a),
        .lane    (cnt_q),
        .operand (in_a),
        .mode    (eff_mode),
        .sign    (eff_a_sign),
        .word_out(ins_a)
    );

    simd_lane_inserter u_ins_b (
        .word_in (base_b),
        .lane    (cnt_q),
        .operand ({{(OP_A_W-OP_B_W){1'b0}}, in_b}),
        .mode    (eff_mode),
        .sign    (eff_b_sign),
        .word_out(ins_b)
    );

    always_comb begin
        asm_a_d      = asm_a_q;
        asm_b_d      = asm_b_q;
        cnt_d        = cnt_q;
        grp_mode_d   = grp_mode_q;
        grp_a_sign_d = grp_a_sign_q;
        grp_b_sign_d = grp_b_sign_q;
        pending_d    = pending_q;
        out_valid_d  = out_valid_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_mode_d   = out_mode_q;
        out_a_sign_d = out_a_sign_q;
        out_b_sign_d = out_b_sign_q;
        out_lanes_d  = out_lanes_q;

        if (out_valid_q & out_ready) out_valid_d = 1'b0;

        // A pending group blocks input, so it never coincides with an accept.
        if (pending_q & out_free) begin
            out_valid_d  = 1'b1;
            out_a_d      = asm_a_q;
            out_b_d      = asm_b_q;
            out_mode_d   = grp_mode_q;
            out_a_sign_d = grp_a_sign_q;
            out_b_sign_d = grp_b_sign_q;
            out_lanes_d  = cnt_q;
            pending_d    = 1'b0;
            cnt_d        = '0;
        end else if (accept) begin
            grp_mode_d   = eff_mode;
            grp_a_sign_d = eff_a_sign;
            grp_b_sign_d = eff_b_sign;
            if (complete & out_free) begin
                out_valid_d  = 1'b1;
                out_a_d      = ins_a;
                out_b_d      = ins_b;
                out_mode_d   = eff_mode;
                out_a_sign_d = eff_a_sign;
                out_b_sign_d = eff_b_sign;
                out_lanes_d  = next_cnt;
                cnt_d        = '0;
            end else begin
                asm_a_d   = ins_a;
                asm_b_d   = ins_b;
                cnt_d     = next_cnt;
                pending_d = complete;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_a_q      <= '0;
            asm_b_q      <= '0;
            cnt_q        <= '0;
            grp_mode_q   <= MODE_27X18;
            grp_a_sign_q <= 1'b0;
            grp_b_sign_q <= 1'b0;
            pending_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_mode_q   <= MODE_27X18;
            out_a_sign_q <= 1'b0;
            out_b_sign_q <= 1'b0;
            out_lanes_q  <= '0;
        end else begin
            asm_a_q      <= asm_a_d;
            asm_b_q      <= asm_b_d;
            cnt_q        <= cnt_d;
            grp_mode_q   <= grp_mode_d;
            grp_a_sign_q <= grp_a_sign_d;
            grp_b_sign_q <= grp_b_sign_d;
            pending_q    <= pending_d;
            out_valid_q  <= out_valid_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_mode_q   <= out_mode_d;
            out_a_sign_q <= out_a_sign_d;
            out_b_sign_q <= out_b_sign_d;
            out_lanes_q  <= out_lanes_d;
        end
    end

    assign out_valid = out_valid_q;
    assign a         = out_a_q;
    assign b         = out_b_q;
    assign mode      = out_mode_q;
    assign a_sign    = out_a_sign_q;
    assign b_sign    = out_b_sign_q;
    assign lanes     = out_lanes_q;

endmodule

// File: tb/tb_simd_operand_packer.sv
// Directed-vector bench for simd_operand_packer with a queue-based scoreboard.
// Stimulus pushes expected groups; an independent monitor pops on each output handshake.
module tb_simd_operand_packer;
    import simd_mult_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [26:0] in_a;
    logic [17:0] in_b;
    logic        in_a_sign, in_b_sign;
    logic [1:0]  in_mode;
    logic        in_last;
    logic        out_valid, out_ready;
    logic [53:0] a, b;
    logic        a_sign, b_sign;
    logic [1:0]  mode;
    logic [3:0]  lanes;

    typedef struct packed {
        logic [53:0] a;
        logic [53:0] b;
        logic [1:0]  mode;
        logic [3:0]  lanes;
        logic        a_sign;
        logic        b_sign;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur, prev;
    logic prev_stall = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    simd_operand_packer dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_a_sign(in_a_sign),
        .in_b_sign(in_b_sign),
        .in_mode  (in_mode),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a        (a),
        .b        (b),
        .a_sign   (a_sign),
        .b_sign   (b_sign),
        .mode     (mode),
        .lanes    (lanes)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [53:0] ea, input logic [53:0] eb, input logic [1:0] em,
                            input logic [3:0] el, input logic eas, input logic ebs);
        exp_t e;
        e.a = ea; e.b = eb; e.mode = em; e.lanes = el; e.a_sign = eas; e.b_sign = ebs;
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [26:0] va, input logic [17:0] vb, input logic vas,
                        input logic vbs, input logic [1:0] vm, input logic vlast);
        int waits = 0;
        in_a = va; in_b = vb; in_a_sign = vas; in_b_sign = vbs; in_mode = vm; in_last = vlast;
        in_valid = 1'b1;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready stayed %0b, wanted 1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        #1;
        cur.a = a; cur.b = b; cur.mode = mode; cur.lanes = lanes;
        cur.a_sign = a_sign; cur.b_sign = b_sign;
        if (reset && prev_stall) check("hold_stable", cur, prev);
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_group: got a=%0h b=%0h lanes=%0d, expected no output", a, b, lanes);
            end else begin
                check("group", cur, exp_q.pop_front());
            end
        end
        prev_stall = reset && out_valid && !out_ready;
        prev       = cur;
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_a_sign = 1'b0;
        in_b_sign = 1'b0; in_mode = 2'b00; in_last = 1'b0; out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_a_b", {a, b}, 0);
        check("rst_mode_lanes_signs", {mode, lanes, a_sign, b_sign}, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 27x18 single lane, one-cycle latency
        push_exp(54'h4000001, 54'h20003, 2'b00, 4'd1, 1'b0, 1'b0);
        send(27'h4000001, 18'h20003, 1'b0, 1'b0, 2'b00, 1'b0);
        check("lat_27x18", out_valid, 1);

        // full sum_9x9; mode and signs on later lanes must be ignored
        push_exp({9'h006, 9'h005, 9'h004, 9'h003, 9'h002, 9'h001},
                 {9'h015, 9'h014, 9'h013, 9'h012, 9'h011, 9'h010}, 2'b01, 4'd6, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            send(27'(k + 1), 18'(16 + k), (k == 0), (k != 0), (k == 0) ? 2'b01 : 2'b00, 1'b0);
            if (k == 4) check("no_early_9x9", out_valid, 0);
        end
        check("lat_9x9", out_valid, 1);

        // early close with in_last
        push_exp(54'h401, 54'h803, 2'b01, 4'd2, 1'b0, 1'b0);
        send(27'd1, 18'd3, 1'b0, 1'b0, 2'b01, 1'b0);
        send(27'd2, 18'd4, 1'b0, 1'b0, 2'b01, 1'b1);

        // mode 11 coerces to sum_9x9
        push_exp(54'h7, 54'h5, 2'b01, 4'd1, 1'b0, 1'b0);
        send(27'd7, 18'd5, 1'b0, 1'b0, 2'b11, 1'b1);

        // sum_4x4 signed nibble pairs
        push_exp(54'h02F, 54'h031, 2'b10, 4'd2, 1'b1, 1'b0);
        send(27'hF, 18'h1, 1'b1, 1'b0, 2'b10, 1'b0);
        send(27'h2, 18'h3, 1'b1, 1'b0, 2'b10, 1'b1);
        push_exp(54'h19F, 54'h180, 2'b10, 4'd2, 1'b1, 1'b1);
        send(27'hF, 18'h0, 1'b1, 1'b1, 2'b10, 1'b0);
        send(27'h9, 18'h8, 1'b1, 1'b1, 2'b10, 1'b1);

        // full 12-lane sum_4x4, unsigned
        push_exp({9'h0BA, 9'h098, 9'h076, 9'h054, 9'h032, 9'h010}, 54'h0, 2'b10, 4'd12, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) send(27'(k), 18'h0, 1'b0, 1'b0, 2'b10, 1'b0);
        check("lat_4x4_full", out_valid, 1);

        // back-to-back 27x18 at full rate
        for (int i = 0; i < 4; i++) begin
            push_exp(54'(27'h5A5A5A0 + 27'(i)), 54'(18'h3C3C0 + 18'(i)), 2'b00, 4'd1, 1'b0, 1'b0);
            send(27'h5A5A5A0 + 27'(i), 18'h3C3C0 + 18'(i), 1'b0, 1'b0, 2'b00, 1'b0);
            check("stream_valid", out_valid, 1);
        end
        @(negedge clk);

        // backpressure: second group pends, third waits behind it
        out_ready = 1'b0;
        push_exp(54'h111, 54'h22, 2'b00, 4'd1, 1'b0, 1'b0);
        send(27'h111, 18'h22, 1'b0, 1'b0, 2'b00, 1'b0);
        push_exp(54'h333, 54'h44, 2'b00, 4'd1, 1'b0, 1'b0);
        send(27'h333, 18'h44, 1'b0, 1'b0, 2'b00, 1'b0);
        check("bp_pending_in_ready", in_ready, 0);
        check("bp_held_a", a, 54'h111);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_released_in_ready", in_ready, 1);
        check("bp_second_a", {out_valid, a}, {1'b1, 54'h333});
        push_exp(54'h555, 54'h66, 2'b00, 4'd1, 1'b0, 1'b0);
        send(27'h555, 18'h66, 1'b0, 1'b0, 2'b00, 1'b0);
        check("bp_third_pending", in_ready, 0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_drained", out_valid, 0);

        // reset in the middle of a group
        for (int k = 0; k < 3; k++) send(27'h1FF, 18'h1FF, 1'b1, 1'b1, 2'b01, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        push_exp({9'h0A5, 9'h0A4, 9'h0A3, 9'h0A2, 9'h0A1, 9'h0A0},
                 {9'h005, 9'h004, 9'h003, 9'h002, 9'h001, 9'h000}, 2'b01, 4'd6, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            send(27'(160 + k), 18'(k), 1'b0, 1'b0, 2'b01, 1'b0);
            if (k == 2) check("midrst_no_residue", out_valid, 0);
        end

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/simd_operand_packer.md
Name: simd_operand_packer

Overview:
- Producer-side front end for the 27x18 / sum-9x9 / sum-4x4 SIMD multiplier.
- Accepts individual lane operand pairs on a valid/ready stream and packs them into the multiplier's 54-bit a/b words.
- Latches the group's mode and sign flags, then presents one packed group per transfer on a valid/ready output.

Parameters:
- SLICE_W, 9, width of one multiplier sub-slice
- N_SLICES, 6, number of sub-slices per packed word
- PACK_W, 54, packed operand width (SLICE_W*N_SLICES)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- in_valid  in  1  lane operand valid
- in_ready  out  1  lane operand accepted when in_valid&in_ready
- in_a  in  27  lane A operand, right-aligned (27/9/4 bits used per mode)
- in_b  in  18  lane B operand, right-aligned (18/9/4 bits used per mode)
- in_a_sign  in  1  A signedness, sampled on first lane of group
- in_b_sign  in  1  B signedness, sampled on first lane of group
- in_mode  in  2  00=27x18, 01=sum_9x9, 10=sum_4x4; sampled on first lane of group
- in_last  in  1  close group early; remaining lanes zero-padded
- out_valid  out  1  packed group available
- out_ready  in  1  consumer accepts group
- a  out  54  packed A word
- b  out  54  packed B word
- a_sign  out  1  latched A sign flag
- b_sign  out  1  latched B sign flag
- mode  out  2  latched mode
- lanes  out  4  number of real (non-padded) lanes in group, 1..12

Behaviour:
- Reset (async, reset=0): out_valid=0; a, b, lanes=0; mode=00; a_sign, b_sign=0; lane counter=0; pending=0; in_ready=1 after release.
- Lanes per group: 27x18=1, sum_9x9=6, sum_4x4=12. in_mode=11 is coerced to 01.
- Mode and sign latch: latched on the accepted lane when lane counter=0. in_mode/in_*_sign changes mid-group are ignored.
- Packing, 27x18: a[26:0]=in_a, b[17:0]=in_b; upper bits 0.
- Packing, sum_9x9: lane k (0..5) at a[9k+8:9k], b[9k+8:9k].
- Packing, sum_4x4: lane k (0..11) in slice s=k/2.
  - Even k: bits [9s+3:9s].
  - Odd k: bits [9s+7:9s+4].
  - Bit 9s+8 = odd lane's operand MSB if its sign flag is set, else 0.
- Padded lanes are all-zero.
- Group completion: lane counter reaches mode lane count, or in_last is accepted (in_last is don't-care in 27x18).
- Two registers: assembly register plus output register.
- On completion: if output register is empty or being drained (out_valid&out_ready) in the same cycle, transfer at the clock edge. Otherwise set pending and hold in_ready=0 until the transfer occurs.
- Latency: completing lane accepted in cycle t → out_valid=1 in cycle t+1.
- Throughput: one group per cycle sustained when out_ready=1 (27x18 at full rate).
- Output stability: a, b, mode, signs, lanes are held stable while out_valid&!out_ready.
- in_ready = !pending.
- Simultaneous cases:
  - Drain and new completion in the same cycle → output reloads, out_valid stays 1.
  - Transfer and new lane accept in the same cycle → the new lane starts a fresh group at counter 0.
- Reset mid-group discards the partial group and any pending/output data.

Decomposition:
- Shared package (simd_mult_pkg): mode encodings MODE_27X18, MODE_SUM_9X9, MODE_SUM_4X4; lane-count constants 1/6/12; SLICE_W.
- Natural sub-module: simd_lane_inserter (combinational). Takes assembly word, lane index, operand, mode and sign; returns updated word.

Test Plan:
- 27x18: mode=00, in_a=27'h4000001, in_b=18'h20003, out_ready=1 → next cycle out_valid=1, a=54'h4000001, b=54'h20003, lanes=1.
- sum_9x9 full group: lanes k=0..5 with in_a=k+1, in_b=9'h10+k → a={9'h006,9'h005,9'h004,9'h003,9'h002,9'h001}, b={9'h015,...,9'h010}, lanes=6, one cycle after 6th accept.
- Early close: sum_9x9, in_a=1 then 2 with in_last on 2nd → a=54'h401, upper bits 0, lanes=2.
- sum_4x4 signed, in_a_sign=1: lane0 a=4'hF, lane1 a=4'h2 → a[8:0]=9'h02F; lane1 a=4'h9 → a[8:0]=9'h19F.
- Backpressure: out_ready=0, stream 27x18 lanes → first output held stable, second group pending, in_ready=0. Then out_ready=1 for one cycle → second group appears and in_ready returns to 1; no lane lost or duplicated.
- Reset mid-group: accept 3 sum_9x9 lanes, pulse reset=0 → out_valid=0, counter cleared. Next 6 lanes form a clean group with no residue.
